// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, with a prefetch FIFO
// that feeds decode over a valid/ready handshake and flushes on redirect.
`default_nettype none

module fetch_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   output logic [XLEN-1:0] addr_out,
   output logic            mem_req,
   input  logic            mem_gnt,
   input  logic [XLEN-1:0] rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic            pop;
   logic            push;
   logic            fifo_empty;
   logic            unused_low_bits;

   assign fifo_empty      = (count == '0);
   assign unused_low_bits = ^redirect_pc[1:0];

   // Redirect masks both sides of the FIFO so a flushed entry is never seen.
   assign instr_valid = ~fifo_empty & ~redirect;
   assign pop         = instr_valid & instr_ready;
   assign mem_req     = (state == RUN) & ~redirect & ((count < DEPTH_C) | pop);
   assign push        = mem_req & mem_gnt;
   assign addr_out    = pc;
   assign instr_out   = fifo_empty ? '0 : instr_mem[rd_ptr];
   assign pc_out      = fifo_empty ? '0 : pc_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state <= fetch_en ? RUN : IDLE;
         if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= {redirect_pc[XLEN-1:2], 2'b00};
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
               pc     <= pc + XLEN'(PC_STEP);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: entries are only observable while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= pc;
         instr_mem[wr_ptr] <= rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl with a queue-based
// reference model of the fetch stream and memory returning ADDR+1.
`default_nettype none

module tb_fetch_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, fetch_en, mem_gnt, instr_ready, redirect;
   logic [31:0] redirect_pc, rdata;
   logic [31:0] addr_out, instr_out, pc_out;
   logic        mem_req, instr_valid;

   logic        rst2, en2;
   logic [31:0] addr2, rdata2, instr2, pc2;
   logic        req2, valid2;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] m_pc;
   bit          m_run;

   always #5 clk = ~clk;

   assign rdata  = addr_out + 32'd1;
   assign rdata2 = addr2 + 32'd1;

   fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .addr_out(addr_out),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .rdata(rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .pc_out(pc_out),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4), .DEPTH(DEPTH)) u_dut_wrap (
      .clk(clk), .rst(rst2), .fetch_en(en2), .addr_out(addr2),
      .mem_req(req2), .mem_gnt(1'b1), .rdata(rdata2),
      .instr_valid(valid2), .instr_ready(1'b1),
      .instr_out(instr2), .pc_out(pc2),
      .redirect(1'b0), .redirect_pc(32'h0)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the fetch stream is a queue of {pc, pc+1} in program order.
   always @(posedge clk or posedge rst) begin : model
      bit p, r;
      if (rst) begin
         exp_q.delete();
         m_pc  = 32'h0;
         m_run = 1'b0;
      end else begin
         if (redirect) begin
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
         end else begin
            p = (exp_q.size() != 0) && instr_ready;
            r = m_run && ((exp_q.size() < DEPTH) || p);
            if (p) void'(exp_q.pop_front());
            if (r && mem_gnt) begin
               exp_q.push_back({m_pc, m_pc + 32'd1});
               m_pc = m_pc + 32'd4;
            end
         end
         m_run = fetch_en;
      end
   end

   always @(negedge clk) begin : monitor
      bit ev, er;
      if (!rst) begin
         ev = (exp_q.size() != 0) && !redirect;
         er = m_run && !redirect && ((exp_q.size() < DEPTH) || (ev && instr_ready));
         check("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
         check("mem_req", {31'd0, mem_req}, {31'd0, er});
         check("addr_out", addr_out, m_pc);
         if (ev) begin
            check("head_pc", pc_out, exp_q[0].pc);
            check("head_instr", instr_out, exp_q[0].ins);
         end else if (exp_q.size() == 0) begin
            check("empty_pc_out", pc_out, 32'h0);
            check("empty_instr_out", instr_out, 32'h0);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin : stim
      logic [31:0] exp5 [4];
      int k;
      exp5 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      rst = 1'b1; rst2 = 1'b1; en2 = 1'b0;
      fetch_en = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      #2;
      check("reset_valid", {31'd0, instr_valid}, 32'd0);
      check("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check("reset_addr", addr_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Free run: first instruction two cycles after enable
      fetch_en = 1'b1; mem_gnt = 1'b1; instr_ready = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      check("t1_pc0", pc_out, 32'h0);
      check("t1_ins0", instr_out, 32'h1);
      @(posedge clk); #3;
      check("t1_pc1", pc_out, 32'h4);
      check("t1_ins1", instr_out, 32'h5);
      repeat (6) @(posedge clk);

      // Decode stall: FIFO fills and the PC holds
      do_reset();
      instr_ready = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      check("t2_req_full", {31'd0, mem_req}, 32'd0);
      check("t2_addr_stall", addr_out, 32'h8);
      check("t2_head_pc", pc_out, 32'h0);
      @(posedge clk); #1;
      instr_ready = 1'b1;
      repeat (6) @(posedge clk);

      // Grant toggling
      for (int i = 0; i < 10; i++) begin
         #1; mem_gnt = i[0];
         @(posedge clk);
      end
      #1; mem_gnt = 1'b1;

      // Redirect with a full FIFO; low address bits are dropped
      instr_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      redirect = 1'b1; redirect_pc = 32'h103;
      #2;
      check("t4_valid_redir", {31'd0, instr_valid}, 32'd0);
      check("t4_req_redir", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      redirect = 1'b0; instr_ready = 1'b1;
      #2;
      check("t4_addr", addr_out, 32'h100);
      @(posedge clk); #3;
      check("t4_pc", pc_out, 32'h100);
      check("t4_ins", instr_out, 32'h101);
      repeat (4) @(posedge clk);

      // Asynchronous reset mid-stream with a full FIFO
      #1; instr_ready = 1'b0;
      repeat (4) @(posedge clk);
      #2; rst = 1'b1;
      #1;
      check("t6_valid", {31'd0, instr_valid}, 32'd0);
      check("t6_instr", instr_out, 32'h0);
      check("t6_pc", pc_out, 32'h0);
      check("t6_req", {31'd0, mem_req}, 32'd0);
      check("t6_addr", addr_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; instr_ready = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      check("t6_restart_pc", pc_out, 32'h0);

      // Randomized traffic, including redirects close to the top of memory
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         fetch_en    = ($urandom_range(0, 9) != 0);
         mem_gnt     = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 29) == 0);
         redirect_pc = ($urandom_range(0, 1) != 0) ? $urandom
                                                   : (32'hFFFF_FFE0 | ($urandom & 32'h1F));
      end
      @(posedge clk); #1;
      redirect = 1'b0; fetch_en = 1'b0;
      repeat (4) @(posedge clk);

      // PC wrap from a high reset value
      #1; rst2 = 1'b0; en2 = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         @(negedge clk);
         if (valid2) begin
            check("t5_wrap_pc", pc2, exp5[k]);
            check("t5_wrap_ins", instr2, exp5[k] + 32'd1);
            k++;
         end
      end
      check("t5_wrap_count", k, 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
